// File: rtl/ret_addr_stack.sv
// Circular return-address stack feeding Ret_reg to the next-PC logic.
// Zero-cycle read of the top entry; pushes and pops take effect at the clock edge.
module ret_addr_stack #(
  parameter int PTR_W = 3,
  parameter int DEPTH = 2**PTR_W,
  parameter int AW    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    In_pc,
  input  logic             branch,
  input  logic             call,
  input  logic             ret,
  input  logic             halt,
  input  logic             stall,
  input  logic             clr_err,
  output logic [AW-1:0]    Ret_reg,
  output logic             empty,
  output logic             full,
  output logic [PTR_W:0]   count,
  output logic             overflow,
  output logic             underflow
);

  logic [AW-1:0]    mem [DEPTH];
  logic [PTR_W-1:0] wp;
  logic [PTR_W-1:0] top_idx;
  logic [PTR_W:0]   cnt;
  logic             push;
  logic             pop;
  logic             halt_unused;

  // Decode priority matches the next-PC mux: branch > call > ret > halt.
  assign push = call & ~branch & ~stall;
  assign pop  = ret & ~branch & ~call & ~stall;
  assign halt_unused = halt;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (PTR_W+1)'(DEPTH));
  assign count   = cnt;
  assign top_idx = wp - PTR_W'(1);
  assign Ret_reg = empty ? '0 : mem[top_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      wp        <= '0;
      cnt       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        // When full the write pointer has wrapped onto the oldest entry.
        mem[wp] <= In_pc + AW'(1);
        wp      <= wp + PTR_W'(1);
        if (!full) begin
          cnt <= cnt + (PTR_W+1)'(1);
        end
      end else if (pop && !empty) begin
        wp  <= wp - PTR_W'(1);
        cnt <= cnt - (PTR_W+1)'(1);
      end
      // A new error event wins over a simultaneous clear.
      overflow  <= (overflow  & ~clr_err) | (push & full);
      underflow <= (underflow & ~clr_err) | (pop & empty);
    end
  end

endmodule

// File: doc/ret_addr_stack.md
Name: ret_addr_stack

Overview:
- Hardware return-address stack that produces the `Ret_reg` value consumed by the next-PC logic.
- Sits beside the PC register, sampling the same decoded control lines (`branch`, `call`, `ret`, `halt`).
- Pushes the return address on every taken call and pops on every taken return.
- Presents the current top-of-stack to the next-PC logic so that a `ret` redirects to the correct address in the same cycle.

Parameters:
- PTR_W, 3, log2 of stack depth.
- DEPTH, 2**PTR_W (8), number of entries. Must equal 2**PTR_W.
- AW, 16, address width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- In_pc  input  AW  current PC (same value driven to the next-PC logic).
- branch  input  1  decoded branch instruction.
- call  input  1  decoded call instruction.
- ret  input  1  decoded return instruction.
- halt  input  1  decoded halt instruction.
- stall  input  1  pipeline hold; suppresses all stack updates.
- clr_err  input  1  clears sticky error flags.
- Ret_reg  output  AW  current top-of-stack return address.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- count  output  PTR_W+1  number of valid entries.
- overflow  output  1  sticky flag: push attempted while full.
- underflow  output  1  sticky flag: pop attempted while empty.

Behaviour:
- Reset (synchronous, rst=1 at rising edge) clears:
  - write pointer `wp` and count to 0;
  - overflow and underflow to 0;
  - all storage entries to 0.
- After reset: Ret_reg=0, empty=1, full=0, count=0.
- rst overrides every other input in the same cycle, including a push or pop in progress.
- Operation decode uses the same priority as the next-PC logic (branch > call > ret > halt):
  - push = call & ~branch & ~stall;
  - pop = ret & ~branch & ~call & ~stall;
  - halt, or no operation, leaves the stack unchanged.
  - call and ret together: push only.
  - stall=1: no push, no pop, flags unchanged (clr_err still acts).
- Push:
  - mem[wp] <= In_pc + 1, computed modulo 2**AW (0xFFFF+1 = 0x0000);
  - wp <= wp + 1, wrapping modulo DEPTH.
  - If not full: count <= count + 1.
  - If full: the oldest entry is overwritten (circular), count stays DEPTH, overflow <= 1.
- Pop:
  - If not empty: wp <= wp - 1 (mod DEPTH), count <= count - 1.
  - If empty: no pointer or count change, underflow <= 1.
- Ret_reg is combinational from registered state:
  - Ret_reg = mem[wp-1] when count != 0, else 0.
  - A `ret` therefore sees the address pushed by the most recent call in the same cycle.
  - After a push, the new value appears on Ret_reg the following cycle (zero-cycle read, one-cycle write latency).
- Pop latency: on the cycle after a pop, Ret_reg shows the previous entry (or 0 if the stack is now empty).
- Flags:
  - clr_err=1 clears overflow and underflow at the clock edge.
  - An error event in the same cycle as clr_err sets the flag (set wins).
  - empty, full and count are combinational from count.
- Entries remain valid after pops; they are not zeroed. Only reset zeroes storage.

Test Plan:
- Reset then idle 3 cycles -> Ret_reg=0x0000, empty=1, count=0, overflow=0, underflow=0.
- In_pc=0x0010, call=1 for one cycle; then In_pc=0x0042, ret=1 -> Ret_reg=0x0011 during the ret cycle, count 1->0, empty=1 next cycle.
- Nested calls at In_pc=0x0100, 0x0200, 0x0300, then three rets -> Ret_reg sequence 0x0301, 0x0201, 0x0101, then 0x0000 with empty=1.
- Nine calls at In_pc=0x1000..0x1008, then eight rets -> overflow=1 after the 9th call, count=8; pops return 0x1009..0x1002 (0x1001 lost).
- ret with empty stack -> underflow=1, count=0, Ret_reg=0. Then clr_err=1 -> underflow=0. Also apply ret+clr_err together on an empty stack -> underflow stays 1.
- call=1 with branch=1 -> no push. call+ret -> push only. call with stall=1 -> no change. call at In_pc=0xFFFF -> Ret_reg=0x0000 with count=1.
- rst asserted in the same cycle as a call while count=3 -> count=0, Ret_reg=0 next cycle.
